// File: rtl/jtkicker_objline.sv
// Sprite row draw engine with a double-buffered 512x4 line buffer and 256x4 colour PROM.
// Optional macro JTKICKER_OBJ_XWRAP_EN: columns past 255 wrap to the left edge instead of being dropped.
module jtkicker_objline #(
  parameter int         BYPASS_PROM = 0,
  parameter logic [7:0] HOFFSET     = 8'd6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic        LHBL,
  input  logic        draw,
  output logic        busy,
  input  logic [8:0]  code,
  input  logic [7:0]  xpos,
  input  logic [3:0]  ysub,
  input  logic [3:0]  pal,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [3:0]  prog_data,
  input  logic [7:0]  prog_addr,
  input  logic        prog_en,
  output logic [13:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  output logic [3:0]  pxl
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLOT  = 2'd2;

  logic [1:0]  state_r;
  logic [8:0]  code_r;
  logic [7:0]  xpos_r;
  logic [3:0]  vrow_r;
  logic [3:0]  pal_r;
  logic        hflip_r;
  logic        half_r;
  logic        first_r;
  logic [2:0]  n_r;
  logic [31:0] data_r;
  logic        wr_sel_r;
  logic        lhbl_q_r;
  logic [7:0]  rd_addr_r;

  logic [3:0]  lbuf_r [0:511];
  logic [3:0]  prom_r [0:255];

  logic        hblank_fall_s;
  logic        accept_s;
  logic [2:0]  nib_idx_s;
  logic [3:0]  nibble_s;
  logic [3:0]  colour_s;
  logic [8:0]  wr_addr_s;
  logic        col_ok_s;
  logic        wr_en_s;
  logic        rd_en_s;

  assign hblank_fall_s = lhbl_q_r & ~LHBL;
  // A draw landing on the blanking edge is taken against the freshly swapped buffer
  assign accept_s      = draw & ((state_r == ST_IDLE) | hblank_fall_s);

  // Horizontal flip walks the latched word from the top nibble down
  assign nib_idx_s = hflip_r ? (3'd7 - n_r) : n_r;
  assign nibble_s  = data_r[{nib_idx_s, 2'b00} +: 4];
  assign colour_s  = (BYPASS_PROM != 0) ? nibble_s : prom_r[{pal_r, nibble_s}];
  assign wr_addr_s = {1'b0, xpos_r} + {5'd0, half_r, n_r};

`ifdef JTKICKER_OBJ_XWRAP_EN
  assign col_ok_s = 1'b1;
`else
  assign col_ok_s = ~wr_addr_s[8];
`endif

  assign wr_en_s = (state_r == ST_PLOT) & ~hblank_fall_s & (colour_s != 4'd0) & col_ok_s;
  assign rd_en_s = LHBL & pxl_cen;

  // Colour PROM download port
  always_ff @(posedge clk) begin
    if (prog_en) prom_r[prog_addr] <= prog_data;
  end

  // Line buffer: sprite writes into wr_sel half, read-side clear-after-read on the other half
  always_ff @(posedge clk) begin
    if (wr_en_s) lbuf_r[{wr_sel_r, wr_addr_s[7:0]}] <= colour_s;
    if (rd_en_s) lbuf_r[{~wr_sel_r, rd_addr_r}] <= 4'd0;
  end

  // Read side: pixel output and read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl       <= 4'd0;
      rd_addr_r <= HOFFSET;
    end else if (!LHBL) begin
      pxl       <= 4'd0;
      rd_addr_r <= HOFFSET;
    end else if (pxl_cen) begin
      pxl       <= lbuf_r[{~wr_sel_r, rd_addr_r}];
      rd_addr_r <= rd_addr_r + 8'd1;
    end
  end

  // Draw FSM, ROM handshake and buffer swap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      busy     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= 14'd0;
      code_r   <= 9'd0;
      xpos_r   <= 8'd0;
      vrow_r   <= 4'd0;
      pal_r    <= 4'd0;
      hflip_r  <= 1'b0;
      half_r   <= 1'b0;
      first_r  <= 1'b0;
      n_r      <= 3'd0;
      data_r   <= 32'd0;
      wr_sel_r <= 1'b0;
      lhbl_q_r <= 1'b0;
    end else begin
      lhbl_q_r <= LHBL;
      if (hblank_fall_s) wr_sel_r <= ~wr_sel_r;
      if (accept_s) begin
        code_r   <= code;
        xpos_r   <= xpos;
        vrow_r   <= ysub ^ {4{vflip}};
        pal_r    <= pal;
        hflip_r  <= hflip;
        half_r   <= 1'b0;
        first_r  <= 1'b1;
        busy     <= 1'b1;
        rom_cs   <= 1'b1;
        rom_addr <= {code, hflip, ysub ^ {4{vflip}}};
        state_r  <= ST_FETCH;
      end else if (hblank_fall_s) begin
        state_r <= ST_IDLE;
        busy    <= 1'b0;
        rom_cs  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_FETCH: begin
            // The first FETCH cycle may still see an ok meant for someone else
            if (first_r) begin
              first_r <= 1'b0;
            end else if (rom_ok) begin
              data_r  <= rom_data;
              rom_cs  <= 1'b0;
              n_r     <= 3'd0;
              state_r <= ST_PLOT;
            end
          end
          ST_PLOT: begin
            n_r <= n_r + 3'd1;
            if (n_r == 3'd7) begin
              if (!half_r) begin
                half_r   <= 1'b1;
                first_r  <= 1'b1;
                rom_cs   <= 1'b1;
                rom_addr <= {code_r, ~hflip_r, vrow_r};
                state_r  <= ST_FETCH;
              end else begin
                busy    <= 1'b0;
                state_r <= ST_IDLE;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            rom_cs  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtkicker_objline.sv
// Self-checking bench for jtkicker_objline: directed cases then random sprite lines
// compared against a pixel-level model of the line buffers.
module tb_jtkicker_objline;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen, LHBL, draw, busy;
  logic [8:0]  code;
  logic [7:0]  xpos;
  logic [3:0]  ysub, pal;
  logic        hflip, vflip;
  logic [3:0]  prog_data;
  logic [7:0]  prog_addr;
  logic        prog_en;
  logic [13:0] rom_addr;
  logic        rom_cs;
  logic [31:0] rom_data;
  logic        rom_ok;
  logic [3:0]  pxl;

  always #10 clk = ~clk;

  jtkicker_objline dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .draw(draw), .busy(busy),
    .code(code), .xpos(xpos), .ysub(ysub), .pal(pal), .hflip(hflip), .vflip(vflip),
    .prog_data(prog_data), .prog_addr(prog_addr), .prog_en(prog_en),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok), .pxl(pxl)
  );

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  prom_m [256];
  logic [3:0]  line_m [2][256];
  logic [3:0]  rd_line [256];
  logic [3:0]  first_px;
  logic        m_sel;
  logic [13:0] addr_q [$];
  int          lat_fixed;
  bit          stale_en, hold_ok, fixed_en;
  logic [31:0] fixed_word;
  int          busy_cycles;
  int          resp_cnt;
  bit          served;

  function automatic logic [31:0] sdram_word(input logic [13:0] a);
    if (fixed_en) return fixed_word;
    return ({18'd0, a} * 32'h9E3779B1) ^ 32'hA5C31E7B;
  endfunction

  // SDRAM stand-in: random latency, optional stale ok pulses while not requested
  always @(posedge clk) begin
    if (rst) begin
      rom_ok <= 1'b0;
      rom_data <= 32'd0;
      served <= 1'b0;
      resp_cnt <= 0;
    end else if (!rom_cs) begin
      rom_ok   <= stale_en && ($urandom_range(0, 1) == 1);
      rom_data <= $urandom;
      served   <= 1'b0;
      resp_cnt <= (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    end else if (served || hold_ok) begin
      rom_ok <= 1'b0;
    end else if (resp_cnt == 0) begin
      rom_ok   <= 1'b1;
      rom_data <= sdram_word(rom_addr);
      served   <= 1'b1;
      addr_q.push_back(rom_addr);
    end else begin
      resp_cnt <= resp_cnt - 1;
      rom_ok   <= 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] q_at(input int i);
    if (i < addr_q.size()) return addr_q[i];
    return 14'h3FFF;
  endfunction

  task automatic load_prom(input bit identity);
    for (int a = 0; a < 256; a++) begin
      prog_addr = 8'(a);
      prog_data = identity ? 4'(a) : 4'($urandom);
      prom_m[a] = prog_data;
      prog_en = 1'b1;
      tick();
    end
    prog_en = 1'b0;
    tick();
  endtask

  // Model: screen column xpos+k shows sprite pixel k (or 15-k when flipped)
  task automatic model_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] ys,
                            input logic [3:0] pl, input logic hf, input logic vf);
    int vrow, p, col;
    logic [31:0] w;
    logic [3:0] nib, colour;
    vrow = vf ? 15 - int'(ys) : int'(ys);
    for (int k = 0; k < 16; k++) begin
      p = hf ? 15 - k : k;
      w = sdram_word({c, (p >= 8) ? 1'b1 : 1'b0, 4'(vrow)});
      nib = w[(p % 8) * 4 +: 4];
      colour = prom_m[{pl, nib}];
      col = int'(x) + k;
      if (colour != 4'd0) begin
        if (col < 256) line_m[m_sel][col] = colour;
`ifdef JTKICKER_OBJ_XWRAP_EN
        else line_m[m_sel][col - 256] = colour;
`endif
      end
    end
  endtask

  task automatic start_draw(input logic [8:0] c, input logic [7:0] x, input logic [3:0] ys,
                            input logic [3:0] pl, input logic hf, input logic vf, input bit model_it);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin tick(); n++; end
    code = c; xpos = x; ysub = ys; pal = pl; hflip = hf; vflip = vf;
    draw = 1'b1;
    tick();
    draw = 1'b0;
    if (model_it) model_draw(c, x, ys, pl, hf, vf);
  endtask

  task automatic wait_idle();
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 1000) begin tick(); busy_cycles++; end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic draw_sprite(input logic [8:0] c, input logic [7:0] x, input logic [3:0] ys,
                             input logic [3:0] pl, input logic hf, input logic vf);
    addr_q.delete();
    start_draw(c, x, ys, pl, hf, vf, 1'b1);
    check("busy_rise", busy, 1'b1);
    wait_idle();
  endtask

  task automatic read_pixels(input bit check_en);
    logic rsel;
    int col;
    rsel = ~m_sel;
    LHBL = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      col = (6 + i) % 256;
      pxl_cen = 1'b1;
      tick();
      pxl_cen = 1'b0;
      rd_line[col] = pxl;
      if (i == 0) first_px = pxl;
      if (check_en) check($sformatf("px_col%0d", col), pxl, line_m[rsel][col]);
      line_m[rsel][col] = 4'd0;
      tick();
    end
  endtask

  task automatic read_line(input bit check_en);
    LHBL = 1'b0;
    tick();
    m_sel = ~m_sel;
    tick();
    tick();
    if (check_en) check("blank_pxl", pxl, 4'd0);
    read_pixels(check_en);
  endtask

  initial begin
    int nz;
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; draw = 1'b0;
    code = 9'd0; xpos = 8'd0; ysub = 4'd0; pal = 4'd0; hflip = 1'b0; vflip = 1'b0;
    prog_data = 4'd0; prog_addr = 8'd0; prog_en = 1'b0;
    lat_fixed = -1; stale_en = 1'b1; hold_ok = 1'b0; fixed_en = 1'b0; fixed_word = 32'd0;
    m_sel = 1'b0;
    for (int s = 0; s < 2; s++) for (int c = 0; c < 256; c++) line_m[s][c] = 4'd0;
    tick(); tick(); tick();
    check("rst_busy", busy, 1'b0);
    check("rst_rom_cs", rom_cs, 1'b0);
    check("rst_rom_addr", rom_addr, 14'd0);
    check("rst_pxl", pxl, 4'd0);
    rst = 1'b0;
    tick();

    load_prom(1'b1);
    read_line(1'b0);
    read_line(1'b0);

    // Basic draw
    lat_fixed = 0; fixed_en = 1'b1; fixed_word = 32'h87654321;
    draw_sprite(9'h005, 8'd40, 4'd3, 4'd0, 1'b0, 1'b0);
    check("basic_cycles", 32'(busy_cycles), 32'd20);
    check("basic_nreq", 32'(addr_q.size()), 32'd2);
    check("basic_addr0", q_at(0), 14'h0A3);
    check("basic_addr1", q_at(1), 14'h0B3);
    read_line(1'b1);
    check("basic_c40", rd_line[40], 4'd1);
    check("basic_c47", rd_line[47], 4'd8);
    check("basic_c48", rd_line[48], 4'd1);
    check("basic_c39", rd_line[39], 4'd0);

    // Flips
    lat_fixed = -1;
    draw_sprite(9'h005, 8'd40, 4'd3, 4'd0, 1'b1, 1'b1);
    check("flip_addr0", q_at(0), {9'h005, 1'b1, 4'd12});
    check("flip_addr1", q_at(1), {9'h005, 1'b0, 4'd12});
    read_line(1'b1);
    check("flip_c40", rd_line[40], 4'd8);
    check("flip_c47", rd_line[47], 4'd1);

    // Transparency and priority
    fixed_word = 32'h55555555;
    draw_sprite(9'h010, 8'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    fixed_word = 32'h03030303;
    draw_sprite(9'h011, 8'd10, 4'd0, 4'd0, 1'b0, 1'b0);
    read_line(1'b1);
    check("prio_c10", rd_line[10], 4'd3);
    check("prio_c11", rd_line[11], 4'd5);
    check("prio_c24", rd_line[24], 4'd3);
    check("prio_c25", rd_line[25], 4'd5);

    // Right edge
    fixed_word = 32'h87654321;
    draw_sprite(9'h020, 8'd250, 4'd0, 4'd0, 1'b0, 1'b0);
    read_line(1'b1);
    check("edge_c250", rd_line[250], 4'd1);
    check("edge_c255", rd_line[255], 4'd6);
`ifdef JTKICKER_OBJ_XWRAP_EN
    check("edge_c0", rd_line[0], 4'd7);
    check("edge_c9", rd_line[9], 4'd8);
`else
    check("edge_c0", rd_line[0], 4'd0);
    check("edge_c9", rd_line[9], 4'd0);
`endif

    // Abort on blanking: finished sprite S must show after the abort swap
    fixed_word = 32'h2222AAAA;
    draw_sprite(9'h030, 8'd60, 4'd2, 4'd0, 1'b0, 1'b0);
    hold_ok = 1'b1;
    start_draw(9'h033, 8'd100, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("abort_busy_pre", busy, 1'b1);
    check("abort_cs_pre", rom_cs, 1'b1);
    LHBL = 1'b0;
    tick();
    m_sel = ~m_sel;
    check("abort_cs", rom_cs, 1'b0);
    check("abort_busy", busy, 1'b0);
    hold_ok = 1'b0;
    read_pixels(1'b1);
    check("abort_c60", rd_line[60], 4'hA);
    check("abort_c100", rd_line[100], 4'd0);

    // Draw while busy issues no new request
    hold_ok = 1'b1;
    addr_q.delete();
    start_draw(9'h044, 8'd20, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick(); tick();
    code = 9'h1FF; ysub = 4'd9; draw = 1'b1;
    tick();
    draw = 1'b0;
    tick();
    check("ign_addr", rom_addr, {9'h044, 1'b0, 4'd5});
    hold_ok = 1'b0;
    wait_idle();
    check("ign_nreq", 32'(addr_q.size()), 32'd2);
    check("ign_addr1", q_at(1), {9'h044, 1'b1, 4'd5});
    read_line(1'b1);

    // Read-and-clear, plus first read lands on column HOFFSET
    fixed_word = 32'h00000009;
    draw_sprite(9'h050, 8'd6, 4'd0, 4'd0, 1'b0, 1'b0);
    read_line(1'b1);
    check("hoff_first", first_px, 4'd9);
    read_line(1'b1);
    read_line(1'b1);
    nz = 0;
    for (int c = 0; c < 256; c++) if (rd_line[c] !== 4'd0) nz++;
    check("clear_all_zero", 32'(nz), 32'd0);

    // Random lines with a random PROM
    fixed_en = 1'b0;
    load_prom(1'b0);
    for (int l = 0; l < 8; l++) begin
      int nd;
      nd = int'($urandom_range(1, 4));
      for (int d = 0; d < nd; d++)
        draw_sprite(9'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom), 1'($urandom));
      read_line(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtkicker_objline.md
Name: jtkicker_objline

Overview:
- Sprite draw engine plus double-buffered line buffer. Sits directly downstream of the sprite table scanner.
- Per draw request: fetches one 16-pixel row of a 16x16 4bpp sprite from SDRAM and maps each pixel through the colour PROM. Opaque pixels are written into the line buffer for the line being built.
- Simultaneously shifts out the previously built line at pixel rate, clearing each entry after it is read.

Parameters:
- BYPASS_PROM, 0: 1 = skip colour PROM; the raw pixel nibble is used as the colour.
- HOFFSET, 8'd6: read-side start address loaded during blanking; aligns sprites with tilemap.

Ports:
- clk  in  1  48 MHz clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable
- LHBL  in  1  active-low horizontal blank
- draw  in  1  one-cycle draw request
- busy  out  1  engine busy; draw ignored while high
- code  in  9  sprite code
- xpos  in  8  leftmost pixel column
- ysub  in  4  row within sprite, 0..15
- pal  in  4  palette
- hflip  in  1  horizontal flip
- vflip  in  1  vertical flip
- prog_data  in  4  PROM download data
- prog_addr  in  8  PROM download address
- prog_en  in  1  PROM write strobe
- rom_addr  out  14  SDRAM word address
- rom_cs  out  1  SDRAM request
- rom_data  in  32  SDRAM data (8 pixels)
- rom_ok  in  1  SDRAM data valid
- pxl  out  4  sprite colour; 0 = transparent

Behaviour:
- Reset values: busy=0, rom_cs=0, rom_addr=0, pxl=0, FSM=IDLE, buffer select=0, rd_addr=HOFFSET. Line buffer RAM content is not reset.
- Request latch: on clk with draw=1 in IDLE, the engine latches code, xpos, ysub, pal, hflip and vflip. busy rises the next cycle.
- Row/half computation: vrow = ysub ^ {4{vflip}}. Two halves h=0 then h=1. Fetched half = h ^ hflip.
- ROM address: rom_addr = {code, h^hflip, vrow}.
- FSM states:
  - IDLE -> FETCH on draw.
  - FETCH: rom_cs=1 with rom_addr held stable. rom_ok is ignored in the first FETCH cycle, because a stale ok may be present. On the first later cycle with rom_ok=1, the engine latches rom_data, drops rom_cs and goes to PLOT.
  - PLOT: 8 cycles, one pixel per clk, n=0..7.
    - Nibble = rom_data[4n+3:4n] if hflip=0, else rom_data[31-4n -: 4].
    - Colour = PROM[{pal,nibble}], or the nibble itself if BYPASS_PROM=1.
    - Write address = xpos + 8*h + n, in 9-bit sum.
    - The pixel is written only if colour != 0, to buffer[wr_sel][addr[7:0]]. Later draws overwrite earlier ones.
  - After PLOT with h=0: h=1, go to FETCH. After PLOT with h=1: go to IDLE, and busy falls that same cycle.
- Timing: minimum draw-to-idle is 2×(2+8) = 20 clk.
- Column overflow: a pixel whose 9-bit address is >255 is discarded. See the optional feature for the alternative.
- Buffer swap: on LHBL falling edge (detected on clk), wr_sel toggles. Any draw in progress is aborted to IDLE with rom_cs=0 and busy=0, and the rest of that sprite is lost.
- draw coincident with the LHBL falling edge: the request is accepted against the new wr_sel.
- Read side (buffer ~wr_sel):
  - While LHBL=0: rd_addr=HOFFSET, pxl=0.
  - On each pxl_cen with LHBL=1: pxl <= entry, the entry is cleared to 0 in the same cycle, then rd_addr++ (8-bit wrap).
  - Read and write never touch the same half.
- Line buffer: 512x4 dual-port, address = {sel, col}.
- Colour PROM: 256x4. Written when prog_en=1 at prog_addr, independent of FSM state.

Optional Feature:
- Macro: JTKICKER_OBJ_XWRAP_EN.
- Defined: pixels whose column exceeds 255 are written at addr[7:0], so sprites wrap to the left edge.
- Undefined: such pixels are discarded (default arcade behaviour).

Test Plan:
- Basic draw: PROM identity, BYPASS_PROM=0; draw code=9'h005, ysub=3, xpos=40, hflip=vflip=0; rom_data=32'h87654321 for both halves. Required: rom_addr=14'h0A3 then 14'h0B3. Next line reads pixels 1..8 at columns 40..47 and 48..55 with the same pattern; other columns read 0.
- Flips: same draw with hflip=1, vflip=1. Required: rom_addr={code,1,12} then {code,0,12}; column 40 reads 8, column 47 reads 1.
- Transparency and priority: sprite A fills columns 10..25 with 5. Then sprite B at xpos=10 with nibbles alternating 0/3. Required: columns read 3,5,3,5...
- Edge handling: xpos=250. Without the macro, columns 250..255 are written and nothing appears at 0..9. With the macro, columns 0..9 also hold data.
- Abort and handshake: hold rom_ok=0 after a draw, then drop LHBL. Required: rom_cs=0 and busy=0 next clk, buffers swap. A draw pulse while busy=1 issues no new ROM request.
- Read-and-clear: after a line is output, a second swap with no draws yields pxl=0 on all 256 columns. The first pxl_cen after LHBL rises reads column HOFFSET=6.
